snac_db15_scan: RTL and testbench

SNAC_DB15_SCAN -- requirements
Module: snac_db15_scan

---
 rtl/snac_db15_scan.sv | 187 ++++++++++++++++++
 tb/tb_snac_db15_scan.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snac_db15_scan.sv
// snac_db15_scan -- scanner for a DB15 SNAC controller adapter built from a
// chain of 74HC165 shift registers (24 button bits, two players).
//
// Each frame runs: LOAD (parallel-load strobe low), then SHIFT (24 bit slots,
// each a low half-phase and then a high half-phase of JOY_CLK), then LATCH
// (one cycle: publish the capture and pulse frame_done), then GAP (idle).
// The frame period is 2*HALF_PERIOD*25 + 1 + GAP_CYCLES clk_50 cycles.
//
// Parameters:
//   HALF_PERIOD  clk_50 cycles per JOY_CLK half-phase (2..255)
//   GAP_CYCLES   idle cycles between frames (1..1023)
//
// Ports:
//   clk_50       the only clock; all logic on its rising edge
//   RESET_L      asynchronous, active-low reset
//   JOY_DATA     serial data from the chain, active-low (0 = pressed)
//   JOY_CLK      shift clock to the chain (registered, glitch-free)
//   JOY_LOAD     parallel-load strobe to the chain, active-low (registered)
//   joystick1    player-1 buttons, active-high, [11:0] live, [15:12] = 0
//   joystick2    player-2 buttons, same format
//   frame_done   one-cycle pulse in the LATCH cycle
//
// Optional feature (macro SNAC_DB15_DEBOUNCE_EN): when defined, the outputs
// only take a new capture if it equals the previous frame's capture; the
// first frame after reset never updates. When undefined, every LATCH loads.
module snac_db15_scan #(
  parameter int HALF_PERIOD = 16,
  parameter int GAP_CYCLES  = 64
) (
  input  logic        clk_50,
  input  logic        RESET_L,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  // Phase counter counts down to zero; each constant is "length - 1".
  localparam logic [9:0] LOAD_LAST = 10'(2 * HALF_PERIOD - 1);
  localparam logic [9:0] HALF_LAST = 10'(HALF_PERIOD - 1);
  localparam logic [9:0] GAP_LAST  = 10'(GAP_CYCLES - 1);
  localparam logic [4:0] NUM_SLOTS = 5'd24;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  state_t      state_q, state_d;
  logic [9:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;          // current slot, saturates at 24
  logic        low_q, low_d;          // in SHIFT: 1 = JOY_CLK low half-phase
  logic [1:0]  sync_q, sync_d;        // JOY_DATA synchronizer
  logic [23:0] capture_q, capture_d;
  logic [23:0] buttons_q, buttons_d;
  logic        joy_clk_q, joy_clk_d;
  logic        joy_load_q, joy_load_d;
  logic        frame_done_q, frame_done_d;
`ifdef SNAC_DB15_DEBOUNCE_EN
  logic [23:0] prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    low_d        = low_q;
    sync_d       = {sync_q[0], JOY_DATA};
    capture_d    = capture_q;
    buttons_d    = buttons_q;
`ifdef SNAC_DB15_DEBOUNCE_EN
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        state_d = LOAD;
        phase_d = LOAD_LAST;
      end
      LOAD: begin
        if (phase_q == '0) begin
          state_d = SHIFT;
          phase_d = HALF_LAST;
          low_d   = 1'b1;
          bit_d   = '0;
        end else begin
          phase_d = phase_q - 10'd1;
        end
      end
      SHIFT: begin
        if (phase_q != '0) begin
          phase_d = phase_q - 10'd1;
        end else if (low_q) begin
          // Last cycle of the low half-phase: the chain output has been
          // stable for the whole half-phase, so take the synchronized bit.
          for (int k = 0; k < 24; k++) begin
            if (bit_q == 5'(k)) begin
              capture_d[k] = ~sync_q[1];
            end
          end
          low_d   = 1'b0;
          phase_d = HALF_LAST;
        end else begin
          bit_d = (bit_q == NUM_SLOTS) ? bit_q : bit_q + 5'd1;
          if (bit_q == NUM_SLOTS - 5'd1) begin
            // Publish on the edge entering LATCH so the new buttons and
            // frame_done become visible in the same cycle.
            state_d = LATCH;
            phase_d = '0;
`ifdef SNAC_DB15_DEBOUNCE_EN
            if (prev_valid_q && (capture_q == prev_q)) begin
              buttons_d = capture_q;
            end
            prev_d       = capture_q;
            prev_valid_d = 1'b1;
`else
            buttons_d = capture_q;
`endif
          end else begin
            low_d   = 1'b1;
            phase_d = HALF_LAST;
          end
        end
      end
      LATCH: begin
        state_d = GAP;
        phase_d = GAP_LAST;
      end
      GAP: begin
        if (phase_q == '0) begin
          state_d = LOAD;
          phase_d = LOAD_LAST;
        end else begin
          phase_d = phase_q - 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chain-facing pins are decoded from the next state and registered.
    joy_load_d   = (state_d != LOAD);
    joy_clk_d    = !((state_d == SHIFT) && low_d);
    frame_done_d = (state_d == LATCH);
  end

  always_ff @(posedge clk_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      low_q        <= 1'b0;
      sync_q       <= 2'b11;
      capture_q    <= '0;
      buttons_q    <= '0;
      joy_clk_q    <= 1'b1;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef SNAC_DB15_DEBOUNCE_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      low_q        <= low_d;
      sync_q       <= sync_d;
      capture_q    <= capture_d;
      buttons_q    <= buttons_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
`ifdef SNAC_DB15_DEBOUNCE_EN
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  assign JOY_CLK    = joy_clk_q;
  assign JOY_LOAD   = joy_load_q;
  assign frame_done = frame_done_q;
  assign joystick1  = {4'b0000, buttons_q[11:0]};
  assign joystick2  = {4'b0000, buttons_q[23:12]};

endmodule

// File: tb/tb_snac_db15_scan.sv
// Bench for snac_db15_scan: one instance at default parameters and one at
// HALF_PERIOD=2 / GAP_CYCLES=1, each driven by a behavioural 74HC165 chain.
// Expected pins come from the cycle number since reset release and the frame
// arithmetic; expected buttons come from the pattern each frame loaded.
module tb_snac_db15_scan;

`ifdef SNAC_DB15_DEBOUNCE_EN
  localparam bit DEBOUNCE = 1'b1;
`else
  localparam bit DEBOUNCE = 1'b0;
`endif

  logic        clk_50 = 1'b0;
  logic        RESET_L = 1'b0;
  logic [1:0]  jd;
  wire  [1:0]  jclk, jload, fd;
  wire  [15:0] j1 [2];
  wire  [15:0] j2 [2];

  always #5 clk_50 = ~clk_50;

  snac_db15_scan dut (
    .clk_50(clk_50), .RESET_L(RESET_L), .JOY_DATA(jd[0]),
    .JOY_CLK(jclk[0]), .JOY_LOAD(jload[0]),
    .joystick1(j1[0]), .joystick2(j2[0]), .frame_done(fd[0])
  );

  snac_db15_scan #(.HALF_PERIOD(2), .GAP_CYCLES(1)) dut_fast (
    .clk_50(clk_50), .RESET_L(RESET_L), .JOY_DATA(jd[1]),
    .JOY_CLK(jclk[1]), .JOY_LOAD(jload[1]),
    .joystick1(j1[1]), .joystick2(j2[1]), .frame_done(fd[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic int hp(input int i);
    return (i == 0) ? 16 : 2;
  endfunction
  function automatic int period(input int i);
    return 50 * hp(i) + 1 + ((i == 0) ? 64 : 1);
  endfunction
  function automatic int phase_of(input int i, input int tt);
    return (tt < 1) ? -1 : (tt - 1) % period(i);
  endfunction

  // {JOY_LOAD, JOY_CLK, frame_done} expected in cycle tt after release.
  function automatic logic [2:0] exp_pins(input int i, input int tt);
    int h, p, q;
    h = hp(i);
    exp_pins = 3'b110;
    if (tt >= 1) begin
      p = (tt - 1) % period(i);
      if (p < 2 * h) exp_pins = 3'b010;
      else if (p < 50 * h) begin
        q = (p - 2 * h) % (2 * h);
        if (q < h) exp_pins = 3'b100;
      end else if (p == 50 * h) exp_pins = 3'b111;
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          t [2];
  logic [23:0] pat_next [2];
  logic [23:0] cur_pat [2];
  logic [23:0] prev_pat [2];
  logic [23:0] exp_js [2];
  logic        have_prev [2];

  always @(posedge clk_50 or negedge RESET_L) begin
    int nt, p;
    for (int i = 0; i < 2; i++) begin
      if (!RESET_L) begin
        t[i] <= 0;
        exp_js[i] <= '0;
        have_prev[i] <= 1'b0;
      end else begin
        nt = t[i] + 1;
        p = phase_of(i, nt);
        t[i] <= nt;
        if (p == 0) cur_pat[i] <= pat_next[i];
        if (p == 50 * hp(i)) begin
          if (!DEBOUNCE || (have_prev[i] && cur_pat[i] == prev_pat[i]))
            exp_js[i] <= cur_pat[i];
          prev_pat[i] <= cur_pat[i];
          have_prev[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------- 74HC165 chain model ----------------
  logic [23:0] sr [2];
  logic [1:0]  ck_seen = 2'b11;
  logic [1:0]  glitch = 2'b00;
  logic        glitch_en = 1'b0;

  always @(negedge clk_50) begin
    for (int i = 0; i < 2; i++) begin
      if (!jload[i]) sr[i] <= pat_next[i];
      else if (jclk[i] && !ck_seen[i]) sr[i] <= {1'b0, sr[i][23:1]};
      ck_seen[i] <= jclk[i];
      // Noise only while JOY_CLK is high; cleared as soon as it goes low.
      glitch[i] <= (i == 0) && glitch_en && jclk[i] && ($urandom_range(0, 1) == 1);
    end
  end

  always_comb begin
    jd[0] = ~sr[0][0] ^ glitch[0];
    jd[1] = ~sr[1][0] ^ glitch[1];
  end

  // ---------------- compare process ----------------
  int   lowrun [2], pulses [2], last_fd [2], nfalls [2], loadrun [2];
  logic pclk [2], pld [2];

  always @(negedge clk_50) begin
    logic [2:0] e;
    for (int i = 0; i < 2; i++) begin
      e = exp_pins(i, t[i]);
      chk("JOY_LOAD", i, 32'(jload[i]), 32'(e[2]));
      chk("JOY_CLK", i, 32'(jclk[i]), 32'(e[1]));
      chk("frame_done", i, 32'(fd[i]), 32'(e[0]));
      chk("joystick1", i, 32'(j1[i]), {20'd0, exp_js[i][11:0]});
      chk("joystick2", i, 32'(j2[i]), {20'd0, exp_js[i][23:12]});
      if (!RESET_L) begin
        lowrun[i] = 0; pulses[i] = 0; last_fd[i] = -1; nfalls[i] = 0; loadrun[i] = 0;
      end else begin
        if (!jclk[i]) lowrun[i]++;
        else if (!pclk[i]) begin
          chk("clk_low_width", i, lowrun[i], (i == 0) ? 16 : 2);
          pulses[i]++;
          lowrun[i] = 0;
        end
        if (!jload[i]) begin
          loadrun[i]++;
          if (pld[i]) begin
            if (nfalls[i] < 2)
              chk("load_fall_cycle", i, t[i], (nfalls[i] == 0) ? 1 : ((i == 0) ? 866 : 103));
            nfalls[i]++;
          end
        end else if (!pld[i]) begin
          chk("load_low_width", i, loadrun[i], (i == 0) ? 32 : 4);
          loadrun[i] = 0;
        end
        if (fd[i]) begin
          chk("clk_pulses", i, pulses[i], 24);
          pulses[i] = 0;
          if (last_fd[i] >= 0) chk("frame_period", i, t[i] - last_fd[i], (i == 0) ? 865 : 102);
          else chk("first_done_cycle", i, t[i], (i == 0) ? 801 : 101);
          last_fd[i] = t[i];
        end
      end
      pclk[i] = jclk[i];
      pld[i] = jload[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_phase(input int i, input int target, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (phase_of(i, t[i]) != target && n < limit);
    if (phase_of(i, t[i]) != target) begin
      checks++;
      errors++;
      $display("FAIL wait_phase inst%0d: phase %0d, expected %0d within %0d cycles",
               i, phase_of(i, t[i]), target, limit);
    end
  endtask

  task automatic check_outs(input string nm, input logic [23:0] v);
    chk({nm, "_j1"}, 0, 32'(j1[0]), {20'd0, v[11:0]});
    chk({nm, "_j2"}, 0, 32'(j2[0]), {20'd0, v[23:12]});
  endtask

  // Fast instance: new pattern (or a repeat) in each single-cycle GAP.
  initial begin
    pat_next[1] = 24'($urandom);
    forever begin
      @(negedge clk_50);
      if (phase_of(1, t[1]) == 101 && $urandom_range(0, 1) == 1)
        pat_next[1] = 24'($urandom);
    end
  end

  initial begin
    logic [23:0] a, b, c;
    logic [23:0] seq [4];
    logic [23:0] want [4];

    pat_next[0] = 24'h801801;     // slots 0, 11, 12, 23 pressed
    repeat (4) @(negedge clk_50);
    chk("reset_j1", 0, 32'(j1[0]), 0);
    chk("reset_clk", 0, 32'(jclk[0]), 1);
    #1 RESET_L = 1'b1;

    // First frame: mapping.
    wait_phase(0, 800, 2000);
    check_outs("map", DEBOUNCE ? 24'h0 : 24'h801801);

    // Debounce sequence A, A, B, A with noise between sampling points.
    glitch_en = 1'b1;
    a = 24'($urandom) | 24'h1;
    b = a ^ 24'h000400;
    seq[0] = a; seq[1] = a; seq[2] = b; seq[3] = a;
    want[0] = DEBOUNCE ? 24'h0 : a;
    want[1] = a;
    want[2] = DEBOUNCE ? a : b;
    want[3] = a;
    for (int j = 0; j < 4; j++) begin
      wait_phase(0, 802, 2000);
      pat_next[0] = seq[j];
      wait_phase(0, 800, 2000);
      check_outs("debounce_seq", want[j]);
    end

    // Reset in the low phase of slot 10.
    wait_phase(0, 32 + 10 * 32 + 4, 2000);
    #2 RESET_L = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_JOY_CLK", i, 32'(jclk[i]), 1);
      chk("async_JOY_LOAD", i, 32'(jload[i]), 1);
      chk("async_frame_done", i, 32'(fd[i]), 0);
      chk("async_j1", i, 32'(j1[i]), 0);
      chk("async_j2", i, 32'(j2[i]), 0);
    end
    c = ~a;
    pat_next[0] = c;
    repeat (3) @(negedge clk_50);
    #1 RESET_L = 1'b1;
    wait_phase(0, 800, 2000);
    check_outs("post_reset", DEBOUNCE ? 24'h0 : c);
    wait_phase(0, 800, 2000);
    check_outs("post_reset2", c);

    // Random frames, sometimes repeating the previous pattern.
    for (int j = 0; j < 4; j++) begin
      wait_phase(0, 802, 2000);
      if ($urandom_range(0, 1) == 1) pat_next[0] = 24'($urandom);
      wait_phase(0, 800, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
